// File: rtl/phys_reg_free_list_pkg.sv
// Shared rename types and sizing constants for the physical register free list.
package phys_reg_free_list_pkg;

   localparam int PHYSICAL_REG_NUM_WIDTH = 7;
   localparam int ARCH_REG_NUM           = 32;
   localparam int MAX_NUM_OF_COMMITS     = 4;

   localparam int PHYS_REG_NUM   = 1 << PHYSICAL_REG_NUM_WIDTH;
   // Registers left unmapped once every architectural register owns one.
   localparam int FREE_LIST_INIT = PHYS_REG_NUM - ARCH_REG_NUM;

   typedef logic [PHYSICAL_REG_NUM_WIDTH-1:0] phys_reg_t;
   typedef logic [PHYSICAL_REG_NUM_WIDTH:0]   count_t;
   typedef logic [$clog2(MAX_NUM_OF_COMMITS+1)-1:0] npush_t;

endpackage

// File: rtl/phys_reg_free_list_if.sv
// Allocation / release bus between the rename and commit stages and the free list.
interface phys_reg_free_list_if;
   import phys_reg_free_list_pkg::*;

   logic                                alloc_req;
   phys_reg_t                           alloc_reg;
   logic                                can_alloc;
   logic [MAX_NUM_OF_COMMITS-1:0]       release_valid;
   phys_reg_t [MAX_NUM_OF_COMMITS-1:0]  release_reg;
   count_t                              free_count;
   logic                                overflow_err;

   // Rename/commit side drives requests and releases.
   modport master (
      output alloc_req, release_valid, release_reg,
      input  alloc_reg, can_alloc, free_count, overflow_err
   );

   // Free list side.
   modport slave (
      input  alloc_req, release_valid, release_reg,
      output alloc_reg, can_alloc, free_count, overflow_err
   );
endinterface

// File: rtl/phys_reg_free_list_release_compactor.sv
// Packs effective release lanes into a hole-free write vector, dropping x0 and
// any lanes that would push the list past its capacity.
module phys_reg_free_list_release_compactor
   import phys_reg_free_list_pkg::*;
(
   input  logic [MAX_NUM_OF_COMMITS-1:0]      release_valid_i,
   input  phys_reg_t [MAX_NUM_OF_COMMITS-1:0] release_reg_i,
   input  count_t                             count_i,
   input  logic                               pop_i,
   output phys_reg_t [MAX_NUM_OF_COMMITS-1:0] wr_vec_o,
   output npush_t                             num_push_o,
   output logic                               overflow_o
);

   int room;
   int n;

   // Walk lanes low to high so the highest lanes are the ones trimmed on overflow.
   always_comb begin
      wr_vec_o   = '0;
      overflow_o = 1'b0;
      n          = 0;
      room       = FREE_LIST_INIT - int'(count_i) + int'(pop_i);
      for (int i = 0; i < MAX_NUM_OF_COMMITS; i++) begin
         if (release_valid_i[i] && (release_reg_i[i] != '0)) begin
            if (n < room) begin
               wr_vec_o[n] = release_reg_i[i];
               n           = n + 1;
            end else begin
               overflow_o = 1'b1;
            end
         end
      end
      num_push_o = npush_t'(n);
   end

endmodule

// File: rtl/phys_reg_free_list.sv
// Circular FIFO of unmapped physical registers: one zero-latency allocation and
// up to MAX_NUM_OF_COMMITS releases per cycle.
module phys_reg_free_list
   import phys_reg_free_list_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   phys_reg_free_list_if.slave  fl
);

   phys_reg_t [PHYS_REG_NUM-1:0]       entries_q;
   phys_reg_t                          head_q, head_d;
   phys_reg_t                          tail_q, tail_d;
   count_t                             count_q, count_d;
   logic                               overflow_err_q, overflow_err_d;

   phys_reg_t [MAX_NUM_OF_COMMITS-1:0] wr_vec;
   npush_t                             num_push;
   logic                               trim;
   logic                               pop;

   assign fl.can_alloc    = (count_q != '0);
   assign fl.alloc_reg    = entries_q[head_q];
   assign fl.free_count   = count_q;
   assign fl.overflow_err = overflow_err_q;

   assign pop = fl.alloc_req && fl.can_alloc;

   phys_reg_free_list_release_compactor u_compactor (
      .release_valid_i (fl.release_valid),
      .release_reg_i   (fl.release_reg),
      .count_i         (count_q),
      .pop_i           (pop),
      .wr_vec_o        (wr_vec),
      .num_push_o      (num_push),
      .overflow_o      (trim)
   );

   // Next pointers and count; releases are never visible to the same-cycle pop.
   always_comb begin
      head_d         = head_q + phys_reg_t'(pop);
      tail_d         = tail_q + phys_reg_t'(num_push);
      count_d        = count_q - count_t'(pop) + count_t'(num_push);
      overflow_err_d = overflow_err_q | trim;
   end

   // Pointer, count and sticky error state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_q         <= '0;
         tail_q         <= phys_reg_t'(FREE_LIST_INIT);
         count_q        <= count_t'(FREE_LIST_INIT);
         overflow_err_q <= 1'b0;
      end else begin
         head_q         <= head_d;
         tail_q         <= tail_d;
         count_q        <= count_d;
         overflow_err_q <= overflow_err_d;
      end
   end

   // Entry storage: reset loads the unmapped registers, releases land at tail onward.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < PHYS_REG_NUM; i++)
            entries_q[i] <= (i < FREE_LIST_INIT) ? phys_reg_t'(i + ARCH_REG_NUM) : '0;
      end else begin
         for (int k = 0; k < MAX_NUM_OF_COMMITS; k++)
            if (k < int'(num_push))
               entries_q[tail_q + phys_reg_t'(k)] <= wr_vec[k];
      end
   end

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Directed bench with a queue-based free-list model and an allocation scoreboard.
module tb_phys_reg_free_list;
   import phys_reg_free_list_pkg::*;

   logic clk = 1'b0;
   logic reset;

   phys_reg_free_list_if bus ();

   phys_reg_free_list dut (
      .clk   (clk),
      .reset (reset),
      .fl    (bus)
   );

   always #5 clk = ~clk;

   int        ncmp  = 0;
   int        nfail = 0;
   int        mdl[$];     // reference free list, front = next allocation
   int        exp_q[$];   // expected alloc_reg values awaiting comparison
   bit        movf;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mdl.delete();
      exp_q.delete();
      for (int i = ARCH_REG_NUM; i < PHYS_REG_NUM; i++) mdl.push_back(i);
      movf = 1'b0;
   endtask

   // One clock cycle; entered and left at a falling edge.
   task automatic step(input bit alloc, input logic [3:0] vld,
                       input int r0, input int r1, input int r2, input int r3);
      int r[4];
      r = '{r0, r1, r2, r3};
      bus.alloc_req     = alloc;
      bus.release_valid = vld;
      for (int i = 0; i < 4; i++) bus.release_reg[i] = phys_reg_t'(r[i]);
      #1;
      chk("can_alloc", 32'(bus.can_alloc), 32'(mdl.size() > 0));
      if (alloc && mdl.size() > 0) begin
         exp_q.push_back(mdl[0]);
         chk("alloc_reg", 32'(bus.alloc_reg), exp_q.pop_front());
         void'(mdl.pop_front());
      end
      for (int i = 0; i < 4; i++)
         if (vld[i] && r[i] != 0) begin
            if (mdl.size() < FREE_LIST_INIT) mdl.push_back(r[i]);
            else movf = 1'b1;
         end
      @(posedge clk);
      @(negedge clk);
      chk("free_count", 32'(bus.free_count), mdl.size());
      chk("overflow_err", 32'(bus.overflow_err), 32'(movf));
      bus.alloc_req     = 1'b0;
      bus.release_valid = '0;
   endtask

   initial begin
      reset             = 1'b1;
      bus.alloc_req     = 1'b0;
      bus.release_valid = '0;
      bus.release_reg   = '0;
      model_reset();
      @(negedge clk);
      reset = 1'b0;

      // Reset image
      chk("rst_alloc_reg", 32'(bus.alloc_reg), 32);
      chk("rst_can_alloc", 32'(bus.can_alloc), 1);
      chk("rst_free_count", 32'(bus.free_count), 96);
      chk("rst_overflow", 32'(bus.overflow_err), 0);

      // Back-to-back allocations then an idle cycle
      for (int i = 0; i < 3; i++) step(1, 4'b0000, 0, 0, 0, 0);
      chk("b2b_free_count", 32'(bus.free_count), 93);
      step(0, 4'b0000, 0, 0, 0, 0);
      chk("idle_alloc_reg", 32'(bus.alloc_reg), 35);

      // Drain to empty; a further request must change nothing
      for (int i = 0; i < 93; i++) step(1, 4'b0000, 0, 0, 0, 0);
      chk("drain_can_alloc", 32'(bus.can_alloc), 0);
      chk("drain_free_count", 32'(bus.free_count), 0);
      step(1, 4'b0000, 0, 0, 0, 0);
      chk("empty_req_count", 32'(bus.free_count), 0);

      // Release while empty: not allocatable this cycle, x0 dropped
      step(0, 4'b1111, 40, 0, 7, 9);
      chk("empty_rel_count", 32'(bus.free_count), 3);
      step(1, 4'b0000, 0, 0, 0, 0);
      step(1, 4'b0000, 0, 0, 0, 0);
      step(1, 4'b0000, 0, 0, 0, 0);

      // Build count=10, then alloc and release in the same cycle
      step(0, 4'b1111, 10, 11, 12, 13);
      step(0, 4'b1111, 14, 15, 16, 17);
      step(0, 4'b0011, 18, 19, 0, 0);
      chk("ten_count", 32'(bus.free_count), 10);
      step(1, 4'b0001, 50, 0, 0, 0);
      chk("simul_count", 32'(bus.free_count), 10);
      for (int i = 0; i < 10; i++) step(1, 4'b0000, 0, 0, 0, 0);

      // From full: single release sets the sticky error
      reset = 1'b1;
      #1;
      reset = 1'b0;
      model_reset();
      step(0, 4'b0001, 60, 0, 0, 0);
      chk("full_ovf", 32'(bus.overflow_err), 1);
      chk("full_count", 32'(bus.free_count), 96);

      // Partial trim: two free slots, four lanes -> lanes 0,1 kept
      step(1, 4'b0000, 0, 0, 0, 0);
      step(1, 4'b0000, 0, 0, 0, 0);
      step(0, 4'b1111, 61, 62, 63, 64);
      chk("trim_count", 32'(bus.free_count), 96);
      for (int i = 0; i < 96; i++) step(1, 4'b0000, 0, 0, 0, 0);

      // Reset mid-stream with traffic in flight
      bus.alloc_req     = 1'b1;
      bus.release_valid = 4'b0001;
      bus.release_reg   = '0;
      bus.release_reg[0] = phys_reg_t'(70);
      reset = 1'b1;
      #1;
      chk("midrst_count", 32'(bus.free_count), 96);
      chk("midrst_ovf", 32'(bus.overflow_err), 0);
      @(posedge clk);
      @(negedge clk);
      reset             = 1'b0;
      bus.alloc_req     = 1'b0;
      bus.release_valid = '0;
      model_reset();
      chk("midrst_alloc_reg", 32'(bus.alloc_reg), 32);
      chk("midrst_can_alloc", 32'(bus.can_alloc), 1);
      step(1, 4'b0000, 0, 0, 0, 0);
      step(1, 4'b0000, 0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
